// File: rtl/cpu_pkg.sv
// Shared RV32I decode types: ALU operation codes, base opcodes and the decoded
// control bundle handed from the decode stage to the execute-stage ALU.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD       = 4'b0000,
        ALU_SLL       = 4'b0001,
        ALU_SLT       = 4'b0010,
        ALU_SLTU      = 4'b0011,
        ALU_XOR       = 4'b0100,
        ALU_SRL       = 4'b0101,
        ALU_OR        = 4'b0110,
        ALU_AND       = 4'b0111,
        ALU_SUB       = 4'b1000,
        ALU_PASS_SRC2 = 4'b1001,
        ALU_SRA       = 4'b1101
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        alu_op_e     alu_ctrl;
        logic [31:0] imm;
        logic        src1_sel;
        logic        src2_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] pc;
        logic        illegal;
    } id_bundle_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic logic is_known_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: is_known_opcode = 1'b1;
            default:                                 is_known_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_decode_buffer_if.sv
// Handshake and bundle signals between fetch, the decode buffer and execute.
interface id_decode_buffer_if;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_ctrl;
    logic [31:0] out_imm;
    logic        out_src1_sel;
    logic        out_src2_sel;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_pc;
    logic        out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_imm, out_src1_sel,
               out_src2_sel, out_rs1, out_rs2, out_rd, out_rd_we, out_pc,
               out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_imm, out_src1_sel,
               out_src2_sel, out_rs1, out_rs2, out_rd, out_rd_we, out_pc,
               out_illegal
    );

endinterface

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: one fetched instruction plus PC in, one
// control bundle out. Illegal opcodes may be rewritten to a NOP.
module id_decoder
    import cpu_pkg::*;
#(
    parameter bit ILLEGAL_AS_NOP = 1'b0
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output id_bundle_t  bundle
);

    logic        known;
    logic [31:0] ins;
    logic [2:0]  funct3;
    logic        writes_rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    // The NOP rewrite happens before field extraction so every field follows it.
    always_comb begin
        known = is_known_opcode(instr[6:0]);
        ins   = (!known && ILLEGAL_AS_NOP) ? NOP_INSTR : instr;
    end

    assign funct3 = ins[14:12];
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        writes_rd = 1'b0;
        bundle     = '0;
        bundle.pc  = pc;
        bundle.rs1 = ins[19:15];
        bundle.rs2 = ins[24:20];
        bundle.rd  = ins[11:7];
        case (ins[6:0])
            OPC_OP: begin
                bundle.alu_ctrl = alu_op_e'({ins[30], funct3});
                writes_rd       = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only shifts-right look at funct7; SUB cannot come from here.
                bundle.alu_ctrl = alu_op_e'({(funct3 == 3'b101) && ins[30], funct3});
                bundle.src2_sel = 1'b1;
                bundle.imm      = imm_i;
                writes_rd       = 1'b1;
            end
            OPC_LUI: begin
                bundle.alu_ctrl = ALU_PASS_SRC2;
                bundle.src2_sel = 1'b1;
                bundle.imm      = imm_u;
                writes_rd       = 1'b1;
            end
            OPC_AUIPC: begin
                bundle.src1_sel = 1'b1;
                bundle.src2_sel = 1'b1;
                bundle.imm      = imm_u;
                writes_rd       = 1'b1;
            end
            OPC_LOAD, OPC_JALR: begin
                bundle.src2_sel = 1'b1;
                bundle.imm      = imm_i;
                writes_rd       = 1'b1;
            end
            OPC_STORE: begin
                bundle.src2_sel = 1'b1;
                bundle.imm      = imm_s;
            end
            OPC_JAL: begin
                bundle.src1_sel = 1'b1;
                bundle.src2_sel = 1'b1;
                bundle.imm      = imm_j;
                writes_rd       = 1'b1;
            end
            OPC_BRANCH: begin
                bundle.src1_sel = 1'b1;
                bundle.src2_sel = 1'b1;
                bundle.imm      = imm_b;
            end
            default: ;
        endcase
        bundle.rd_we   = writes_rd && (ins[11:7] != 5'd0);
        bundle.illegal = !known;
    end

endmodule

// File: rtl/id_decode_buffer.sv
// RV32I decode stage: decodes on the input side and holds decoded bundles in
// a 2-entry skid buffer (main + skid) with valid/ready on both sides.
//
// state     | meaning
// BUF_EMPTY | nothing buffered, out_valid low
// BUF_ONE   | main entry valid and presented downstream
// BUF_FULL  | main presented, skid holds the next bundle, in_ready low
module id_decode_buffer
    import cpu_pkg::*;
#(
    parameter bit ILLEGAL_AS_NOP = 1'b0
) (
    input logic               clk,
    input logic               rst,
    id_decode_buffer_if.slave bus
);

    buf_state_e state_q;
    buf_state_e state_d;
    id_bundle_t main_q;
    id_bundle_t main_d;
    id_bundle_t skid_q;
    id_bundle_t skid_d;
    id_bundle_t dec_bundle;

    logic accept;
    logic in_ready;
    logic out_valid;
    logic load_main_dec;
    logic load_main_skid;
    logic load_skid;

    id_decoder #(
        .ILLEGAL_AS_NOP (ILLEGAL_AS_NOP)
    ) u_id_decoder (
        .instr  (bus.in_instr),
        .pc     (bus.in_pc),
        .bundle (dec_bundle)
    );

    // in_ready depends on registered state only, never on out_ready.
    assign accept = bus.in_valid && (state_q != BUF_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (accept) state_d = BUF_ONE;
                BUF_ONE: begin
                    if (accept && !bus.out_ready) begin
                        state_d = BUF_FULL;
                    end else if (!accept && bus.out_ready) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL:  if (bus.out_ready) state_d = BUF_ONE;
                default:   state_d = BUF_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready       = (state_q != BUF_FULL);
        out_valid      = (state_q != BUF_EMPTY);
        load_main_dec  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                BUF_EMPTY: load_main_dec = accept;
                BUF_ONE: begin
                    load_main_dec = accept && bus.out_ready;
                    load_skid     = accept && !bus.out_ready;
                end
                BUF_FULL:  load_main_skid = bus.out_ready;
                default: ;
            endcase
        end
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main_skid) begin
            main_d = skid_q;
        end else if (load_main_dec) begin
            main_d = dec_bundle;
        end
        if (load_skid) begin
            skid_d = dec_bundle;
        end
    end

    // Data registers are only cleared by reset; a flush just drops validity.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_alu_ctrl = main_q.alu_ctrl;
    assign bus.out_imm      = main_q.imm;
    assign bus.out_src1_sel = main_q.src1_sel;
    assign bus.out_src2_sel = main_q.src2_sel;
    assign bus.out_rs1      = main_q.rs1;
    assign bus.out_rs2      = main_q.rs2;
    assign bus.out_rd       = main_q.rd;
    assign bus.out_rd_we    = main_q.rd_we;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_id_decode_buffer.sv
// Scoreboard bench for id_decode_buffer: two instances (illegal passthrough and
// illegal-as-NOP) share stimulus; a reference decoder fills expected queues.
module tb_id_decode_buffer;

    typedef struct {
        logic [3:0]  alu;
        logic [31:0] imm;
        logic        s1;
        logic        s2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] pc;
        logic        ill;
        bit          chk_imm;
        bit          chk_ops;
    } exp_t;

    logic clk;
    logic rst;
    bit   mon_on;
    int   n_checks;
    int   n_fail;
    int   occ;
    int   occ_nxt;
    exp_t q0[$];
    exp_t q1[$];
    exp_t g0;
    exp_t g1;
    exp_t e0;
    exp_t e1;
    logic [31:0] ri;
    logic [31:0] rpc;
    logic [6:0]  ops [0:8] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    id_decode_buffer_if bus0 ();
    id_decode_buffer_if bus1 ();

    id_decode_buffer #(.ILLEGAL_AS_NOP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    id_decode_buffer #(.ILLEGAL_AS_NOP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input bit nop);
        exp_t e;
        int   si;
        bit   wr;
        si = int'(i);
        wr = 1'b0;
        e.pc = pc;   e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        e.ill = 1'b0; e.alu = 4'b0000; e.imm = 32'd0; e.s1 = 1'b0; e.s2 = 1'b0;
        e.chk_imm = 1'b1; e.chk_ops = 1'b1;
        case (i[6:0])
            7'b0110011: begin e.alu = {i[30], i[14:12]}; wr = 1'b1; e.chk_imm = 1'b0; end
            7'b0010011: begin
                e.alu = (i[14:12] == 3'b101) ? {i[30], 3'b101} : {1'b0, i[14:12]};
                e.s2 = 1'b1; e.imm = 32'(si >>> 20); wr = 1'b1;
            end
            7'b0110111: begin e.alu = 4'b1001; e.s2 = 1'b1; e.imm = i & 32'hFFFF_F000; wr = 1'b1; end
            7'b0010111: begin e.s1 = 1'b1; e.s2 = 1'b1; e.imm = i & 32'hFFFF_F000; wr = 1'b1; end
            7'b0000011, 7'b1100111: begin e.s2 = 1'b1; e.imm = 32'(si >>> 20); wr = 1'b1; end
            7'b0100011: begin e.s2 = 1'b1; e.imm = 32'((si >>> 25) * 32 + int'(i[11:7])); end
            7'b1101111: begin
                e.s1 = 1'b1; e.s2 = 1'b1; wr = 1'b1;
                e.imm = 32'((si >>> 31) * 1048576 + int'(i[19:12]) * 4096
                            + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
            end
            7'b1100011: begin
                e.s1 = 1'b1; e.s2 = 1'b1;
                e.imm = 32'((si >>> 31) * 4096 + int'(i[7]) * 2048
                            + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
            end
            default: begin
                e.ill = 1'b1;
                if (nop) begin
                    e.rs1 = 5'd0; e.rs2 = 5'd0; e.rd = 5'd0; e.s2 = 1'b1; e.imm = 32'd0;
                end else begin
                    e.chk_imm = 1'b0; e.chk_ops = 1'b0;
                end
            end
        endcase
        e.rd_we = wr && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk_entry(input string p, input exp_t e, input exp_t g);
        chk({p, " alu_ctrl"}, 32'(g.alu), 32'(e.alu));
        chk({p, " pc"}, g.pc, e.pc);
        chk({p, " illegal"}, 32'(g.ill), 32'(e.ill));
        chk({p, " rd_we"}, 32'(g.rd_we), 32'(e.rd_we));
        if (e.chk_imm) chk({p, " imm"}, g.imm, e.imm);
        if (e.chk_ops) begin
            chk({p, " src1_sel"}, 32'(g.s1), 32'(e.s1));
            chk({p, " src2_sel"}, 32'(g.s2), 32'(e.s2));
            chk({p, " rs1"}, 32'(g.rs1), 32'(e.rs1));
            chk({p, " rs2"}, 32'(g.rs2), 32'(e.rs2));
            chk({p, " rd"}, 32'(g.rd), 32'(e.rd));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic r);
        bit acc;
        bit pop;
        @(posedge clk);
        #1;
        occ = occ_nxt;
        rst = r;
        bus0.in_valid = v;    bus1.in_valid = v;
        bus0.in_instr = ins;  bus1.in_instr = ins;
        bus0.in_pc = pc;      bus1.in_pc = pc;
        bus0.out_ready = ordy; bus1.out_ready = ordy;
        bus0.flush = fl;      bus1.flush = fl;
        if (r || fl) begin
            q0.delete();
            q1.delete();
            occ_nxt = 0;
        end else begin
            acc = v && (occ < 2);
            pop = ordy && (occ > 0);
            if (acc) begin
                q0.push_back(model(ins, pc, 1'b0));
                q1.push_back(model(ins, pc, 1'b1));
            end
            occ_nxt = occ + int'(acc) - int'(pop);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("p0 out_valid", 32'(bus0.out_valid), 32'(occ != 0));
            chk("p0 in_ready", 32'(bus0.in_ready), 32'(occ != 2));
            if (bus0.out_valid && bus0.out_ready && !bus0.flush && !rst) begin
                g0.alu = bus0.out_alu_ctrl; g0.imm = bus0.out_imm;
                g0.s1 = bus0.out_src1_sel;  g0.s2 = bus0.out_src2_sel;
                g0.rs1 = bus0.out_rs1; g0.rs2 = bus0.out_rs2; g0.rd = bus0.out_rd;
                g0.rd_we = bus0.out_rd_we; g0.pc = bus0.out_pc; g0.ill = bus0.out_illegal;
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL p0 unexpected output: got pc %h expected no output", g0.pc);
                end else begin
                    e0 = q0.pop_front();
                    chk_entry("p0", e0, g0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("p1 out_valid", 32'(bus1.out_valid), 32'(occ != 0));
            chk("p1 in_ready", 32'(bus1.in_ready), 32'(occ != 2));
            if (bus1.out_valid && bus1.out_ready && !bus1.flush && !rst) begin
                g1.alu = bus1.out_alu_ctrl; g1.imm = bus1.out_imm;
                g1.s1 = bus1.out_src1_sel;  g1.s2 = bus1.out_src2_sel;
                g1.rs1 = bus1.out_rs1; g1.rs2 = bus1.out_rs2; g1.rd = bus1.out_rd;
                g1.rd_we = bus1.out_rd_we; g1.pc = bus1.out_pc; g1.ill = bus1.out_illegal;
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL p1 unexpected output: got pc %h expected no output", g1.pc);
                end else begin
                    e1 = q1.pop_front();
                    chk_entry("p1", e1, g1);
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0; occ = 0; occ_nxt = 0; mon_on = 1'b0;
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        bus0.in_instr = '0;   bus1.in_instr = '0;
        bus0.in_pc = '0;      bus1.in_pc = '0;
        bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
        bus0.flush = 1'b0;    bus1.flush = 1'b0;

        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("reset out_valid", 32'(bus0.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus0.in_ready), 32'd1);
        chk("reset alu_ctrl", 32'(bus0.out_alu_ctrl), 32'd0);
        chk("reset imm", bus0.out_imm, 32'd0);
        chk("reset pc", bus0.out_pc, 32'd0);
        chk("reset illegal", 32'(bus0.out_illegal), 32'd0);
        chk("reset rd_we", 32'(bus0.out_rd_we), 32'd0);
        chk("reset p1 out_valid", 32'(bus1.out_valid), 32'd0);
        mon_on = 1'b1;

        // sub / srai / lui with a ready consumer
        drive(1'b1, 32'h4020_81B3, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h4043_5293, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h1234_53B7, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // backpressure: fill to FULL, third offer refused, then drain in order
        drive(1'b1, 32'h0011_0093, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0020_8133, 32'h0000_0204, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0031_01B3, 32'h0000_0208, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0031_01B3, 32'h0000_0208, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // flush while FULL with a new offer: all three are dropped
        drive(1'b1, 32'h0050_0293, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0060_0313, 32'h0000_0304, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0070_0393, 32'h0000_0308, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // illegal opcode with nonzero fields, then addi x0,x0,1
        drive(1'b1, 32'hFFF0_A2FF, 32'h0000_0400, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h0010_0013, 32'h0000_0404, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        rpc = 32'h0000_1000;
        for (int n = 0; n < 3000; n++) begin
            ri = $urandom;
            if ($urandom_range(7) != 0) ri[6:0] = ops[$urandom_range(8)];
            drive(($urandom_range(3) != 0), ri, rpc, ($urandom_range(2) != 0),
                  ($urandom_range(31) == 0), ($urandom_range(199) == 0));
            rpc = rpc + 32'd4;
        end

        for (int n = 0; n < 4; n++) drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("p0 leftover entries", 32'(q0.size()), 32'd0);
        chk("p1 leftover entries", 32'(q1.size()), 32'd0);
        mon_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
